// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit multiplexed 7-segment display path:
// digit geometry, the segment-off pattern and the hex glyph table.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;
  localparam int IDX_W      = 3;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-high glyphs, bit 0 = segment a ... bit 6 = segment g
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F,  // 0
    7'h06,  // 1
    7'h5B,  // 2
    7'h4F,  // 3
    7'h66,  // 4
    7'h6D,  // 5
    7'h7D,  // 6
    7'h07,  // 7
    7'h7F,  // 8
    7'h6F,  // 9
    7'h77,  // A
    7'h7C,  // b
    7'h39,  // C
    7'h5E,  // d
    7'h79,  // E
    7'h71   // F
  };

  function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [IDX_W-1:0] idx);
    anode_sel = ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex digit to active-low segment decoder for a common-anode display.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic [6:0]         seg
);

  always_comb begin
    seg = ~SEG_TABLE[code];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan driver for an 8-digit common-anode display with frame snapshot
// and per-slot blanking. Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         en,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [IDX_W-1:0]              scan_idx
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0]              cnt_p0;
  logic [NUM_DIGITS*DIGIT_W-1:0] snap_digits_p0;
  logic [NUM_DIGITS-1:0]         snap_dp_p0;
  logic [NUM_DIGITS-1:0]         snap_en_p0;
  logic                          frame_start;

  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  upper_zero;
  logic [DIGIT_W-1:0]    cur_code;
  logic [6:0]            dec_seg;
  logic                  lit;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  assign frame_start = (cnt_p0 == '0) && (scan_idx == '0);

  // Stage p0: slot timing and frame snapshot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p0   <= '0;
      scan_idx <= '0;
    end else if (cnt_p0 == CNT_MAX) begin
      cnt_p0   <= '0;
      scan_idx <= scan_idx + IDX_W'(1);
    end else begin
      cnt_p0   <= cnt_p0 + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_digits_p0 <= '0;
      snap_dp_p0     <= '0;
      snap_en_p0     <= '0;
    end else if (frame_start) begin
      snap_digits_p0 <= digits;
      snap_dp_p0     <= dp_in;
      snap_en_p0     <= en;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit goes dark when it and every enabled digit to its left are zero
  always_comb begin
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (upper_zero && (snap_digits_p0[k*DIGIT_W +: DIGIT_W] == '0))
        lz_blank[k] = 1'b1;
      if (snap_en_p0[k] && (snap_digits_p0[k*DIGIT_W +: DIGIT_W] != '0))
        upper_zero = 1'b0;
    end
  end
`else
  always_comb begin
    lz_blank   = '0;
    upper_zero = 1'b0;
  end
`endif

  assign cur_code = snap_digits_p0[scan_idx*DIGIT_W +: DIGIT_W];

  seg7_decode u_decode (
    .code (cur_code),
    .seg  (dec_seg)
  );

  always_comb begin
    lit     = (cnt_p0 >= BLANK_LIM) && snap_en_p0[scan_idx] && !lz_blank[scan_idx];
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (lit) begin
      an_nxt  = anode_sel(scan_idx);
      seg_nxt = dec_seg;
      dp_nxt  = ~snap_dp_p0[scan_idx];
    end
  end

  // Stage p1: registered pin drivers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: time-based reference model plus directed literal checks,
// and a second instance exercising the anode invariants under random inputs.
module tb_seg7_scan_driver;

  localparam int T  = 4;
  localparam int B  = 1;
  localparam int T2 = 5;
  localparam int B2 = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] digits;
  logic [7:0]  dp_in, en;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  scan_idx;

  logic [31:0] digits2;
  logic [7:0]  dp_in2, en2;
  logic [7:0]  an2;
  logic [6:0]  seg2;
  logic        dp2;
  logic [2:0]  scan_idx2;

  int checks = 0;
  int errors = 0;
  int e = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.TICK_DIV(T), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .digits(digits), .dp_in(dp_in), .en(en),
    .an(an), .seg(seg), .dp(dp), .scan_idx(scan_idx)
  );

  seg7_scan_driver #(.TICK_DIV(T2), .BLANK_CYCLES(B2)) dut2 (
    .clk(clk), .reset(reset), .digits(digits2), .dp_in(dp_in2), .en(en2),
    .an(an2), .seg(seg2), .dp(dp2), .scan_idx(scan_idx2)
  );

  // Common-anode glyph codes (active-low, bit0=a)
  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'h0: ref_seg = 7'h40;  4'h1: ref_seg = 7'h79;
      4'h2: ref_seg = 7'h24;  4'h3: ref_seg = 7'h30;
      4'h4: ref_seg = 7'h19;  4'h5: ref_seg = 7'h12;
      4'h6: ref_seg = 7'h02;  4'h7: ref_seg = 7'h78;
      4'h8: ref_seg = 7'h00;  4'h9: ref_seg = 7'h10;
      4'hA: ref_seg = 7'h08;  4'hB: ref_seg = 7'h03;
      4'hC: ref_seg = 7'h46;  4'hD: ref_seg = 7'h21;
      4'hE: ref_seg = 7'h06;  default: ref_seg = 7'h0E;
    endcase
  endfunction

  function automatic logic [3:0] nib(input logic [31:0] d, input int k);
    nib = 4'((d >> (4 * k)) & 32'hF);
  endfunction

  // Is the slot scanned at absolute time n lit, given the frame's snapshot?
  function automatic bit ref_lit(input int n, input logic [31:0] d, input logic [7:0] m_en);
    int slot, hi;
    bit lz;
    slot = (n / T) % 8;
    hi = -1;
    for (int j = 0; j < 8; j++)
      if (m_en[j] && nib(d, j) != 4'h0) hi = j;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lz = (slot >= 1) && (slot > hi);
`else
    lz = 1'b0;
`endif
    ref_lit = ((n % T) >= B) && m_en[slot] && !lz;
  endfunction

  int          n, n2, prev2;
  logic [31:0] s_dig;
  logic [7:0]  s_dp, s_en;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [2:0]  e_idx;
  logic        v2;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n <= 0; s_dig <= '0; s_dp <= '0; s_en <= '0;
      e_an <= 8'hFF; e_seg <= 7'h7F; e_dp <= 1'b1; e_idx <= '0;
    end else begin
      e_an  <= ref_lit(n, s_dig, s_en) ? ~(8'h01 << ((n / T) % 8)) : 8'hFF;
      e_seg <= ref_lit(n, s_dig, s_en) ? ref_seg(nib(s_dig, (n / T) % 8)) : 7'h7F;
      e_dp  <= ref_lit(n, s_dig, s_en) ? ~s_dp[(n / T) % 8] : 1'b1;
      if (n % (8 * T) == 0) begin
        s_dig <= digits; s_dp <= dp_in; s_en <= en;
      end
      n     <= n + 1;
      e_idx <= 3'(((n + 1) / T) % 8);
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n2 <= 0; prev2 <= 0; v2 <= 1'b0;
    end else begin
      prev2 <= n2 % T2;
      n2    <= n2 + 1;
      v2    <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at e=%0d: got %0h expected %0h", name, e, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
    chk("model_an", 32'(an), 32'(e_an));
    chk("model_seg", 32'(seg), 32'(e_seg));
    chk("model_dp", 32'(dp), 32'(e_dp));
    chk("model_idx", 32'(scan_idx), 32'(e_idx));
    if (v2) begin
      chk("inv_onehot", 32'($countones(~an2) <= 1), 32'd1);
      if (prev2 < B2) chk("inv_blank", 32'(an2), 32'hFF);
    end
    digits2 = $urandom;
    en2     = 8'($urandom);
    dp_in2  = 8'($urandom);
  endtask

  task automatic run_to(input int target);
    while (e < target) step();
  endtask

  initial begin
    reset = 1'b1;
    digits = 32'h76543210; en = 8'hFF; dp_in = 8'h00;
    digits2 = '0; en2 = '0; dp_in2 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset asserted mid-slot
    run_to(7);
    chk("pre_reset_an", 32'(an), 32'hFD);
    reset = 1'b1;
    #1;
    chk("async_an", 32'(an), 32'hFF);
    chk("async_seg", 32'(seg), 32'h7F);
    chk("async_dp", 32'(dp), 32'd1);
    chk("async_idx", 32'(scan_idx), 32'd0);
    step();
    reset = 1'b0;
    e = 0;

    // Scan order
    run_to(1);  chk("t1_blank0", 32'(an), 32'hFF);
    run_to(2);  chk("t1_an0", 32'(an), 32'hFE); chk("t1_seg0", 32'(seg), 32'h40);
    run_to(7);  chk("t1_an1", 32'(an), 32'hFD); chk("t1_seg1", 32'(seg), 32'h79);
    run_to(28); chk("t1_idx7", 32'(scan_idx), 32'd7);
    run_to(29); chk("t1_blank7", 32'(an), 32'hFF);
    run_to(32); chk("t1_an7", 32'(an), 32'h7F); chk("t1_seg7", 32'(seg), 32'h78);
    chk("t1_wrap", 32'(scan_idx), 32'd0);

    // Snapshot isolation
    digits = 32'h00000000;
    run_to(45); chk("t2_idx3", 32'(scan_idx), 32'd3);
    digits = 32'h99999999;
    run_to(54); chk("t2_old_an", 32'(an), 32'hDF); chk("t2_old_seg", 32'(seg), 32'h40);
    run_to(86); chk("t2_new_an", 32'(an), 32'hDF); chk("t2_new_seg", 32'(seg), 32'h10);

    // Enable and decimal point
    en = 8'h0F; dp_in = 8'h02;
    run_to(98);  chk("t3_dp_off0", 32'(dp), 32'd1);
    run_to(102); chk("t3_an1", 32'(an), 32'hFD); chk("t3_dp_on1", 32'(dp), 32'd0);
    run_to(114); chk("t3_dis_an", 32'(an), 32'hFF); chk("t3_dis_seg", 32'(seg), 32'h7F);

    // Hex glyphs
    digits = 32'h0000000A;
    run_to(130); chk("t4_segA", 32'(seg), 32'h08);
    digits = 32'h0000000F;
    run_to(162); chk("t4_segF", 32'(seg), 32'h0E);

    // Leading-zero behaviour
    digits = 32'h00000305; en = 8'hFF; dp_in = 8'h80;
    run_to(198); chk("t6_an1", 32'(an), 32'hFD); chk("t6_seg1", 32'(seg), 32'h40);
    run_to(202); chk("t6_an2", 32'(an), 32'hFB); chk("t6_seg2", 32'(seg), 32'h30);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    run_to(206); chk("t6_an3", 32'(an), 32'hFF);
    run_to(222); chk("t6_an7", 32'(an), 32'hFF); chk("t6_dp7", 32'(dp), 32'd1);
`else
    run_to(206); chk("t6_an3", 32'(an), 32'hF7);
    run_to(222); chk("t6_an7", 32'(an), 32'h7F); chk("t6_dp7", 32'(dp), 32'd0);
    chk("t6_seg7", 32'(seg), 32'h40);
`endif
    run_to(230);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
